// File: rtl/prgrom_responder.sv
`default_nettype none
// ============================================================================
// Module      : prgrom_responder
// Description : Instruction-memory responder for the fetch stage. It returns
//               the 32-bit word at the previous cycle's word address, and it
//               owns a byte-stream download port that rewrites program memory
//               from word 0 upward while holding the CPU.
// Ports       : clock, reset      - clock and synchronous active-high reset
//               rom_read_addr     - word address from the fetch stage
//               Instruction       - registered read data (NOP_WORD while busy)
//               upg_start/upg_len - download start pulse and word count
//               upg_valid/upg_byte- download byte stream, little-endian words
//               upg_ready         - byte stream is accepted (LOAD only)
//               cpu_hold          - stall request while a download is active
//               upg_done          - one-cycle completion pulse
//               upg_wr_count      - words written by the current/last download
// Revision    : 1.0 - initial release
// ============================================================================
module prgrom_responder #(
  parameter int          ADDR_WIDTH = 14,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] rom_read_addr,
  output logic [31:0]           Instruction,
  input  logic                  upg_start,
  input  logic [ADDR_WIDTH:0]   upg_len,
  input  logic                  upg_valid,
  input  logic [7:0]            upg_byte,
  output logic                  upg_ready,
  output logic                  cpu_hold,
  output logic                  upg_done,
  output logic [ADDR_WIDTH:0]   upg_wr_count
);

  localparam int                c_DEPTH   = 2 ** ADDR_WIDTH;
  // Largest legal length: exactly one full memory.
  localparam logic [ADDR_WIDTH:0] c_MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;

  logic [31:0]           r_mem [0:c_DEPTH-1];
  logic [31:0]           r_instr;
  logic [1:0]            r_byte_cnt;
  // Only lanes 0..2 are buffered; lane 3 goes straight into the memory write.
  logic [23:0]           r_buf;
  logic [ADDR_WIDTH:0]   r_len;
  logic [ADDR_WIDTH:0]   r_wr_count;

  logic                  w_accept;
  logic                  w_lane3;
  logic                  w_word_wr;
  logic                  w_last_word;
  logic [ADDR_WIDTH:0]   w_len_clamped;
  logic [ADDR_WIDTH:0]   w_wr_count_inc;

  // Any length with the top bit set is >= 2**ADDR_WIDTH, so it clamps to one
  // full memory and the write address can never wrap back to word 0.
  assign w_len_clamped  = upg_len[ADDR_WIDTH] ? c_MAX_LEN : upg_len;
  assign w_accept       = upg_valid && (r_state == S_LOAD);
  assign w_lane3        = (r_byte_cnt == 2'd3);
  assign w_wr_count_inc = r_wr_count + {{ADDR_WIDTH{1'b0}}, 1'b1};
  assign w_last_word    = (w_wr_count_inc == r_len);
  // Reset wins over a coincident final byte so an interrupted word is dropped.
  assign w_word_wr      = w_accept && w_lane3 && !reset;

  // --------------------------------------------------------------------------
  // Next-state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    upg_ready    = 1'b0;
    cpu_hold     = 1'b0;
    upg_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (upg_start) begin
          w_state_next = (upg_len == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        upg_ready = 1'b1;
        cpu_hold  = 1'b1;
        if (w_word_wr && w_last_word) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        cpu_hold     = 1'b1;
        upg_done     = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Control, byte assembly and fetch read register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_instr    <= 32'h0000_0000;
      r_byte_cnt <= 2'd0;
      r_buf      <= 24'h00_0000;
      r_len      <= '0;
      r_wr_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_instr <= (r_state == S_IDLE) ? r_mem[rom_read_addr] : NOP_WORD;

      if ((r_state == S_IDLE) && upg_start) begin
        r_len      <= w_len_clamped;
        r_wr_count <= '0;
        r_byte_cnt <= 2'd0;
      end

      if (w_accept) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        case (r_byte_cnt)
          2'd0:    r_buf[7:0]   <= upg_byte;
          2'd1:    r_buf[15:8]  <= upg_byte;
          2'd2:    r_buf[23:16] <= upg_byte;
          default: r_wr_count   <= w_wr_count_inc;
        endcase
      end
    end
  end

  // Program memory: never reset, so words from an aborted download survive.
  always_ff @(posedge clock) begin
    if (w_word_wr) begin
      r_mem[r_wr_count[ADDR_WIDTH-1:0]] <= {upg_byte, r_buf};
    end
  end

  assign Instruction  = r_instr;
  assign upg_wr_count = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_prgrom_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_prgrom_responder
// Description : Self-checking bench for prgrom_responder (ADDR_WIDTH=4). A
//               word-array model of program memory is filled from the byte
//               stream in little-endian order; fetch reads and download
//               handshake timing are compared against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prgrom_responder;

  localparam int          AW    = 4;
  localparam int          DEPTH = 16;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  logic          clock;
  logic          reset;
  logic [AW-1:0] rom_read_addr;
  logic [31:0]   Instruction;
  logic          upg_start;
  logic [AW:0]   upg_len;
  logic          upg_valid;
  logic [7:0]    upg_byte;
  logic          upg_ready;
  logic          cpu_hold;
  logic          upg_done;
  logic [AW:0]   upg_wr_count;

  int            total;
  int            bad;
  logic [31:0]   model_mem [DEPTH];
  bit            model_ok  [DEPTH];
  logic [7:0]    byte_q [$];

  prgrom_responder #(
    .ADDR_WIDTH (AW),
    .NOP_WORD   (NOP)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .rom_read_addr (rom_read_addr),
    .Instruction   (Instruction),
    .upg_start     (upg_start),
    .upg_len       (upg_len),
    .upg_valid     (upg_valid),
    .upg_byte      (upg_byte),
    .upg_ready     (upg_ready),
    .cpu_hold      (cpu_hold),
    .upg_done      (upg_done),
    .upg_wr_count  (upg_wr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    byte_q.push_back(w[7:0]);
    byte_q.push_back(w[15:8]);
    byte_q.push_back(w[23:16]);
    byte_q.push_back(w[31:24]);
  endtask

  task automatic push_random_words(input int n);
    for (int i = 0; i < n; i++) push_word($urandom);
  endtask

  task automatic read_word(input logic [AW-1:0] a, output logic [31:0] d);
    rom_read_addr = a;
    tick();
    d = Instruction;
  endtask

  // Drives one download of byte_q and checks handshake timing as it goes.
  // gap_mode: 0 = every cycle, 1 = valid every other cycle, 2 = random.
  // restart_at >= 0 pulses a stray upg_start when that many bytes are in.
  task automatic run_download(input int len, input int gap_mode, input int restart_at);
    int eff, need, acc, cyc;
    bit v, first, restarted;
    eff = (len > DEPTH) ? DEPTH : len;
    need = eff * 4;
    upg_start = 1'b1;
    upg_len   = (AW+1)'(len);
    tick();
    upg_start = 1'b0;
    total++;
    if (cpu_hold !== 1'b1) begin
      bad++; $display("FAIL dl_hold_start: got %b want 1", cpu_hold);
    end
    if (eff == 0) begin
      total++;
      if (upg_done !== 1'b1 || upg_wr_count !== '0 || upg_ready !== 1'b0) begin
        bad++; $display("FAIL dl_zero_done: done=%b cnt=%0d rdy=%b want 1/0/0", upg_done, upg_wr_count, upg_ready);
      end
      tick();
      total++;
      if (cpu_hold !== 1'b0 || upg_done !== 1'b0) begin
        bad++; $display("FAIL dl_zero_idle: hold=%b done=%b want 0/0", cpu_hold, upg_done);
      end
      byte_q.delete();
      return;
    end
    acc = 0; cyc = 0; first = 1'b1; restarted = 1'b0;
    while (acc < need && cyc < 4000) begin
      total++;
      if (upg_ready !== 1'b1 || upg_done !== 1'b0 || cpu_hold !== 1'b1 ||
          upg_wr_count !== (AW+1)'(acc / 4)) begin
        bad++;
        $display("FAIL dl_progress: rdy=%b done=%b hold=%b cnt=%0d want 1/0/1/%0d",
                 upg_ready, upg_done, cpu_hold, upg_wr_count, acc / 4);
      end
      if (!first) begin
        total++;
        if (Instruction !== NOP) begin
          bad++; $display("FAIL dl_nop: got %h want %h", Instruction, NOP);
        end
      end
      first = 1'b0;
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      upg_valid = v;
      upg_byte  = v ? byte_q[acc] : 8'($urandom);
      if (restart_at >= 0 && !restarted && acc == restart_at) begin
        upg_start = 1'b1;
        upg_len   = (AW+1)'(len + 3);
        restarted = 1'b1;
      end
      tick();
      cyc++;
      upg_start = 1'b0;
      upg_len   = (AW+1)'(len);
      if (v) acc++;
    end
    upg_valid = 1'b0;
    upg_byte  = 8'($urandom);
    if (acc < need) begin
      total++; bad++;
      $display("FAIL dl_timeout: accepted %0d bytes want %0d", acc, need);
    end
    total++;
    if (upg_done !== 1'b1 || cpu_hold !== 1'b1 || upg_ready !== 1'b0 ||
        upg_wr_count !== (AW+1)'(eff) || Instruction !== NOP) begin
      bad++;
      $display("FAIL dl_done: done=%b hold=%b rdy=%b cnt=%0d ins=%h want 1/1/0/%0d/%h",
               upg_done, cpu_hold, upg_ready, upg_wr_count, Instruction, eff, NOP);
    end
    tick();
    total++;
    if (upg_done !== 1'b0 || cpu_hold !== 1'b0 || Instruction !== NOP ||
        upg_wr_count !== (AW+1)'(eff)) begin
      bad++;
      $display("FAIL dl_back_idle: done=%b hold=%b ins=%h cnt=%0d want 0/0/%h/%0d",
               upg_done, cpu_hold, Instruction, upg_wr_count, NOP, eff);
    end
    for (int w = 0; w < eff; w++) begin
      model_mem[w] = {byte_q[4*w+3], byte_q[4*w+2], byte_q[4*w+1], byte_q[4*w]};
      model_ok[w]  = 1'b1;
    end
    byte_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++;
    if (Instruction !== 32'h0 || upg_ready !== 1'b0 || cpu_hold !== 1'b0 ||
        upg_done !== 1'b0 || upg_wr_count !== '0) begin
      bad++;
      $display("FAIL reset_state: ins=%h rdy=%b hold=%b done=%b cnt=%0d want 0/0/0/0/0",
               Instruction, upg_ready, cpu_hold, upg_done, upg_wr_count);
    end
    reset = 1'b0;
  endtask

  task automatic test_read_latency();
    logic [31:0] d;
    push_word(32'h0044_0820);
    push_word(32'h1181_ffff);
    push_word(32'h0104_4022);
    push_word(32'h1500_fffe);
    run_download(4, 0, -1);
    for (int i = 0; i < 4; i++) begin
      read_word(AW'(i), d);
      total++;
      if (d !== model_mem[i]) begin
        bad++; $display("FAIL read_latency[%0d]: got %h want %h", i, d, model_mem[i]);
      end
    end
    for (int i = 0; i < 6; i++) begin
      int a;
      a = $urandom_range(0, 3);
      read_word(AW'(a), d);
      total++;
      if (d !== model_mem[a]) begin
        bad++; $display("FAIL read_random[%0d]: got %h want %h", a, d, model_mem[a]);
      end
    end
  endtask

  task automatic test_download_two();
    logic [31:0] d;
    logic [7:0]  seq [8];
    seq = '{8'h20, 8'h08, 8'h44, 8'h00, 8'h22, 8'h40, 8'h04, 8'h01};
    foreach (seq[i]) byte_q.push_back(seq[i]);
    run_download(2, 1, -1);
    read_word(AW'(0), d);
    total++;
    if (d !== 32'h0044_0820) begin
      bad++; $display("FAIL two_word0: got %h want 00440820", d);
    end
    read_word(AW'(1), d);
    total++;
    if (d !== 32'h0104_4022) begin
      bad++; $display("FAIL two_word1: got %h want 01044022", d);
    end
    read_word(AW'(3), d);
    total++;
    if (d !== 32'h1500_fffe) begin
      bad++; $display("FAIL two_untouched3: got %h want 1500fffe", d);
    end
  endtask

  task automatic test_zero_length();
    logic [31:0] d;
    run_download(0, 0, -1);
    for (int i = 0; i < DEPTH; i++) begin
      if (model_ok[i]) begin
        read_word(AW'(i), d);
        total++;
        if (d !== model_mem[i]) begin
          bad++; $display("FAIL zero_len_mem[%0d]: got %h want %h", i, d, model_mem[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    push_random_words(3);
    upg_start = 1'b1;
    upg_len   = (AW+1)'(3);
    tick();
    upg_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      upg_valid = 1'b1;
      upg_byte  = byte_q[i];
      tick();
    end
    upg_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_mem[0] = {byte_q[3], byte_q[2], byte_q[1], byte_q[0]};
    byte_q.delete();
    total++;
    if (cpu_hold !== 1'b0 || upg_wr_count !== '0 || upg_ready !== 1'b0 ||
        upg_done !== 1'b0 || Instruction !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid_state: hold=%b cnt=%0d rdy=%b done=%b ins=%h want 0/0/0/0/0",
               cpu_hold, upg_wr_count, upg_ready, upg_done, Instruction);
    end
    read_word(AW'(0), d);
    total++;
    if (d !== model_mem[0]) begin
      bad++; $display("FAIL reset_mid_word0: got %h want %h", d, model_mem[0]);
    end
    read_word(AW'(1), d);
    total++;
    if (d !== model_mem[1]) begin
      bad++; $display("FAIL reset_mid_word1: got %h want %h", d, model_mem[1]);
    end
  endtask

  task automatic test_ignored();
    logic [31:0] d;
    for (int i = 0; i < 8; i++) begin
      upg_valid = 1'b1;
      upg_byte  = 8'($urandom);
      tick();
      total++;
      if (upg_ready !== 1'b0 || cpu_hold !== 1'b0 || upg_wr_count !== '0) begin
        bad++; $display("FAIL idle_bytes: rdy=%b hold=%b cnt=%0d want 0/0/0", upg_ready, cpu_hold, upg_wr_count);
      end
    end
    upg_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      read_word(AW'(i), d);
      total++;
      if (d !== model_mem[i]) begin
        bad++; $display("FAIL idle_bytes_mem[%0d]: got %h want %h", i, d, model_mem[i]);
      end
    end
    push_random_words(2);
    run_download(2, 2, 5);
    for (int i = 0; i < 4; i++) begin
      read_word(AW'(i), d);
      total++;
      if (d !== model_mem[i]) begin
        bad++; $display("FAIL restart_mem[%0d]: got %h want %h", i, d, model_mem[i]);
      end
    end
  endtask

  task automatic test_full_depth();
    logic [31:0] d;
    push_random_words(DEPTH);
    run_download(31, 2, -1);
    for (int i = 0; i < DEPTH; i++) begin
      read_word(AW'(i), d);
      total++;
      if (d !== model_mem[i]) begin
        bad++; $display("FAIL full_depth[%0d]: got %h want %h", i, d, model_mem[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    for (int r = 0; r < 4; r++) begin
      int len;
      len = $urandom_range(1, 20);
      push_random_words((len > DEPTH) ? DEPTH : len);
      run_download(len, $urandom_range(0, 2), -1);
      for (int i = 0; i < 6; i++) begin
        int a;
        a = $urandom_range(0, DEPTH - 1);
        if (model_ok[a]) begin
          read_word(AW'(a), d);
          total++;
          if (d !== model_mem[a]) begin
            bad++; $display("FAIL b2b_read[%0d]: got %h want %h", a, d, model_mem[a]);
          end
        end
      end
    end
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    reset         = 1'b1;
    rom_read_addr = '0;
    upg_start     = 1'b0;
    upg_len       = '0;
    upg_valid     = 1'b0;
    upg_byte      = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = 32'h0;
      model_ok[i]  = 1'b0;
    end
    test_reset();
    test_read_latency();
    test_download_two();
    test_zero_length();
    test_reset_mid();
    test_ignored();
    test_full_depth();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
